// File: rtl/feature_window_unloader.sv
// rtl/feature_window_unloader.sv - snapshot a 6-word feature window and stream it oldest-first with a running sum
module feature_window_unloader #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 6,
  parameter int IDX_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     win_valid,
  input  logic                     win_update,
  input  logic signed [DATA_W-1:0] din_stage1,
  input  logic signed [DATA_W-1:0] din_stage2,
  input  logic signed [DATA_W-1:0] din_stage3,
  input  logic signed [DATA_W-1:0] din_stage4,
  input  logic signed [DATA_W-1:0] din_stage5,
  input  logic signed [DATA_W-1:0] din_stage6,
  output logic signed [DATA_W-1:0] dout,
  output logic [IDX_W-1:0]         dout_idx,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic signed [DATA_W+2:0] sum_out,
  output logic                     sum_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int SUM_W = DATA_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     overrun_q, overrun_d;
  logic                     load;

  // Buffer slot 0 holds the oldest stage so the index counts in stream order.
  logic signed [DATA_W-1:0] buf_q [DEPTH];

  logic                     capture;
  logic                     streaming;
  logic                     handshake;
  logic signed [DATA_W-1:0] word_sel;
  logic signed [SUM_W-1:0]  word_ext;

  assign capture   = win_update & win_valid;
  assign streaming = (state_q == S_STREAM);
  assign handshake = streaming & dout_ready;
  assign word_ext  = {{(SUM_W - DATA_W){word_sel[DATA_W-1]}}, word_sel};

  // Select the buffered word for the current index with an explicit mux so
  // the unused index codes resolve to zero instead of an out-of-range read.
  always_comb begin
    word_sel = '0;
    case (idx_q)
      3'd0:    word_sel = buf_q[0];
      3'd1:    word_sel = buf_q[1];
      3'd2:    word_sel = buf_q[2];
      3'd3:    word_sel = buf_q[3];
      3'd4:    word_sel = buf_q[4];
      3'd5:    word_sel = buf_q[5];
      default: word_sel = '0;
    endcase
  end

  // Next-state logic: capture only from IDLE, accumulate on each handshake,
  // flag any window offered while the previous one is still in flight.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (capture) begin
          overrun_d = 1'b1;
        end
        if (handshake) begin
          acc_d = acc_q + word_ext;
          if (idx_q == LAST_IDX) begin
            sum_d   = acc_q + word_ext;
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (capture) begin
          overrun_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      overrun_q <= overrun_d;
    end
  end

  // Window snapshot, loaded only on an accepted capture so a dropped window
  // leaves the word being streamed untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (load) begin
      buf_q[0] <= din_stage6;
      buf_q[1] <= din_stage5;
      buf_q[2] <= din_stage4;
      buf_q[3] <= din_stage3;
      buf_q[4] <= din_stage2;
      buf_q[5] <= din_stage1;
    end
  end

  // Outputs are decoded from registered state only, so dout_valid never
  // depends on dout_ready and the offered word stays stable until accepted.
  assign dout       = streaming ? word_sel : '0;
  assign dout_idx   = streaming ? idx_q : '0;
  assign dout_valid = streaming;
  assign dout_last  = streaming & (idx_q == LAST_IDX);
  assign sum_out    = sum_q;
  assign sum_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_STREAM) | (state_q == S_DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_feature_window_unloader.sv
// tb/tb_feature_window_unloader.sv - scoreboard bench for feature_window_unloader
module tb_feature_window_unloader;

  localparam int DW = 37;
  localparam int SW = 40;

  logic                 clk;
  logic                 rst;
  logic                 win_valid;
  logic                 win_update;
  logic signed [DW-1:0] din_stage1, din_stage2, din_stage3;
  logic signed [DW-1:0] din_stage4, din_stage5, din_stage6;
  logic signed [DW-1:0] dout;
  logic [2:0]           dout_idx;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic signed [SW-1:0] sum_out;
  logic                 sum_valid;
  logic                 busy;
  logic                 overrun;

  feature_window_unloader #(.DATA_W(DW), .DEPTH(6), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .win_valid  (win_valid),
    .win_update (win_update),
    .din_stage1 (din_stage1),
    .din_stage2 (din_stage2),
    .din_stage3 (din_stage3),
    .din_stage4 (din_stage4),
    .din_stage5 (din_stage5),
    .din_stage6 (din_stage6),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic signed [DW-1:0] d;
    logic [2:0]           idx;
    logic                 last;
  } word_t;

  word_t                exp_words[$];
  logic signed [SW-1:0] exp_sums[$];

  int total = 0;
  int bad   = 0;
  int words_seen = 0;
  int ready_mode = 0;
  int ready_ph   = 0;

  localparam logic signed [DW-1:0] NEG36 = {1'b1, 36'b0};
  localparam logic signed [SW-1:0] SUM_SIGNED = -40'sd137438953472 + 40'sd5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_window(input logic signed [DW-1:0] s1, s2, s3, s4, s5, s6,
                             input logic signed [SW-1:0] es);
    word_t w;
    logic signed [DW-1:0] vals [6];
    vals[0] = s6; vals[1] = s5; vals[2] = s4;
    vals[3] = s3; vals[4] = s2; vals[5] = s1;
    for (int i = 0; i < 6; i++) begin
      w.d    = vals[i];
      w.idx  = 3'(i);
      w.last = (i == 5);
      exp_words.push_back(w);
    end
    exp_sums.push_back(es);
  endtask

  task automatic capture(input logic signed [DW-1:0] s1, s2, s3, s4, s5, s6, input logic wv);
    @(posedge clk); #1;
    din_stage1 = s1; din_stage2 = s2; din_stage3 = s3;
    din_stage4 = s4; din_stage5 = s5; din_stage6 = s6;
    win_valid  = wv;
    win_update = 1'b1;
    @(posedge clk); #1;
    win_update = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_words.size() != 0 || exp_sums.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s timeout: busy=%0d words_left=%0d sums_left=%0d required all zero",
               name, busy, exp_words.size(), exp_sums.size());
    end
  endtask

  // Ready driver: 0 = always high, 1 = repeating 1,0,0 pattern, 2 = held low.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: begin
        dout_ready = (ready_ph == 0);
        ready_ph   = (ready_ph + 1) % 3;
      end
      default: dout_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted word and every sum pulse,
  // and checks that a stalled word is held unchanged.
  logic                 stall;
  logic signed [DW-1:0] stall_d;
  logic [2:0]           stall_idx;
  initial stall = 1'b0;

  always @(negedge clk) begin
    word_t w;
    logic signed [SW-1:0] es;
    if (!rst) begin
      if (stall && dout_valid) begin
        chk("stall_dout", 64'(dout), 64'(stall_d));
        chk("stall_idx", 64'(dout_idx), 64'(stall_idx));
      end
      if (dout_valid) begin
        if (dout_ready) begin
          stall = 1'b0;
          words_seen++;
          if (exp_words.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got dout=%0d idx=%0d, no word expected", dout, dout_idx);
          end else begin
            w = exp_words.pop_front();
            chk("dout", 64'(dout), 64'(w.d));
            chk("dout_idx", 64'(dout_idx), 64'(w.idx));
            chk("dout_last", 64'(dout_last), 64'(w.last));
          end
        end else begin
          stall     = 1'b1;
          stall_d   = dout;
          stall_idx = dout_idx;
        end
      end else begin
        stall = 1'b0;
      end
      if (sum_valid) begin
        if (exp_sums.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_sum: got sum_out=%0d, no sum expected", sum_out);
        end else begin
          es = exp_sums.pop_front();
          chk("sum_out", 64'(sum_out), 64'(es));
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    win_valid = 1'b0; win_update = 1'b0; dout_ready = 1'b1;
    din_stage1 = '0; din_stage2 = '0; din_stage3 = '0;
    din_stage4 = '0; din_stage5 = '0; din_stage6 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_idx", 64'(dout_idx), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout_last", 64'(dout_last), 64'd0);
    chk("rst_sum_out", 64'(sum_out), 64'd0);
    chk("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Basic stream with latency checks.
    push_window(37'sd10, 37'sd20, 37'sd30, 37'sd40, 37'sd50, 37'sd60, 40'sd210);
    capture(37'sd10, 37'sd20, 37'sd30, 37'sd40, 37'sd50, 37'sd60, 1'b1);
    chk("basic_valid_n1", 64'(dout_valid), 64'd1);
    chk("basic_idx_n1", 64'(dout_idx), 64'd0);
    chk("basic_busy_n1", 64'(busy), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("basic_sum_valid_n7", 64'(sum_valid), 64'd1);
    chk("basic_busy_n7", 64'(busy), 64'd1);
    chk("basic_valid_n7", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    chk("basic_busy_n8", 64'(busy), 64'd0);
    chk("basic_sum_valid_n8", 64'(sum_valid), 64'd0);
    chk("basic_sum_hold", 64'(sum_out), 64'(40'sd210));
    wait_done("basic");

    // Signed extremes.
    push_window(-37'sd5, NEG36, 37'sd3, 37'sd0, 37'sd7, NEG36, SUM_SIGNED);
    capture(-37'sd5, NEG36, 37'sd3, 37'sd0, 37'sd7, NEG36, 1'b1);
    wait_done("signed");
    chk("signed_sum_hold", 64'(sum_out), 64'(SUM_SIGNED));

    // Backpressure.
    ready_mode = 1;
    push_window(-37'sd1, 37'sd100, -37'sd1000, 37'sd7, 37'sd0, 37'sd33, -40'sd861);
    capture(-37'sd1, 37'sd100, -37'sd1000, 37'sd7, 37'sd0, 37'sd33, 1'b1);
    wait_done("backpressure");
    ready_mode = 0;

    // Update without a full window is ignored.
    capture(37'sd1, 37'sd2, 37'sd3, 37'sd4, 37'sd5, 37'sd6, 1'b0);
    chk("notfull_valid", 64'(dout_valid), 64'd0);
    chk("notfull_busy", 64'(busy), 64'd0);
    chk("notfull_overrun", 64'(overrun), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("notfull_busy_later", 64'(busy), 64'd0);

    // Overrun: second window during STREAM is dropped.
    win_valid = 1'b1;
    push_window(37'sd11, 37'sd22, 37'sd33, 37'sd44, 37'sd55, 37'sd66, 40'sd231);
    capture(37'sd11, 37'sd22, 37'sd33, 37'sd44, 37'sd55, 37'sd66, 1'b1);
    capture(37'sd99, 37'sd99, 37'sd99, 37'sd99, 37'sd99, 37'sd99, 1'b1);
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_done("overrun");
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("overrun_idle", 64'(busy), 64'd0);

    // Reset after three accepted words.
    base = words_seen;
    push_window(37'sd1000, 37'sd2000, 37'sd3000, 37'sd4000, 37'sd5000, 37'sd6000, 40'sd21000);
    capture(37'sd1000, 37'sd2000, 37'sd3000, 37'sd4000, 37'sd5000, 37'sd6000, 1'b1);
    n = 0;
    while (words_seen < base + 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_reached", 64'(words_seen - base >= 3), 64'd1);
    rst = 1'b1;
    ready_mode = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_words.delete();
    exp_sums.delete();
    chk("rstmid_valid", 64'(dout_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_sum_valid", 64'(sum_valid), 64'd0);
    chk("rstmid_dout", 64'(dout), 64'd0);
    chk("rstmid_idx", 64'(dout_idx), 64'd0);
    chk("rstmid_last", 64'(dout_last), 64'd0);
    chk("rstmid_sum_out", 64'(sum_out), 64'd0);
    chk("rstmid_overrun", 64'(overrun), 64'd0);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_still_idle", 64'(busy), 64'd0);

    // A following window streams normally.
    push_window(37'sd5, 37'sd4, 37'sd3, 37'sd2, 37'sd1, -37'sd100, -40'sd85);
    capture(37'sd5, 37'sd4, 37'sd3, 37'sd2, 37'sd1, -37'sd100, 1'b1);
    wait_done("after_reset");
    chk("final_overrun", 64'(overrun), 64'd0);
    chk("final_words_left", 64'(exp_words.size()), 64'd0);
    chk("final_sums_left", 64'(exp_sums.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
